// File: rtl/arm7tdmi_instr_decode.sv
// Registered ARM7TDMI decode stage: splits an ARM word or Thumb halfword into
// class, register, immediate, memory, branch, shift, PSR and coprocessor fields.

package arm7tdmi_pkg;

   typedef enum logic [3:0] {
      COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
      COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
   } condition_t;

   typedef enum logic [3:0] {
      IT_DATA_PROC, IT_MUL, IT_MUL_LONG, IT_SWAP, IT_BRANCH_EX, IT_HALF_DT,
      IT_SINGLE_DT, IT_UNDEF, IT_BLOCK_DT, IT_BRANCH, IT_CP_DT, IT_CP_OP,
      IT_CP_RT, IT_SWI, IT_PSR
   } instr_type_t;

   typedef enum logic [3:0] {
      ALU_AND, ALU_EOR, ALU_SUB, ALU_RSB, ALU_ADD, ALU_ADC, ALU_SBC, ALU_RSC,
      ALU_TST, ALU_TEQ, ALU_CMP, ALU_CMN, ALU_ORR, ALU_MOV, ALU_BIC, ALU_MVN
   } alu_op_t;

   typedef struct packed {
      condition_t  condition;
      instr_type_t instr_type;
      alu_op_t     alu_op;
      logic [3:0]  rd, rn, rm;
      logic [11:0] immediate;
      logic        imm_en, set_flags, is_memory;
      logic        mem_load, mem_byte, mem_pre, mem_up, mem_writeback;
      logic [31:0] pc;
      logic        valid;
      logic        is_branch;
      logic [23:0] branch_offset;
      logic        branch_link;
      logic [1:0]  shift_type;
      logic [4:0]  shift_amount;
      logic        shift_reg;
      logic [3:0]  shift_rs;
      logic        psr_to_reg, psr_spsr, psr_immediate;
      logic [3:0]  cp_op, cp_num, cp_rd, cp_rn;
      logic [2:0]  cp_opcode1, cp_opcode2;
      logic        cp_load;
      logic [4:0]  thumb_instr_type;
      logic [2:0]  thumb_rd, thumb_rs, thumb_rn;
      logic [7:0]  thumb_imm8;
      logic [4:0]  thumb_imm5;
      logic [10:0] thumb_offset11;
      logic [7:0]  thumb_offset8;
   } decode_t;

endpackage

module arm7tdmi_instr_decode
   import arm7tdmi_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instruction,
   input  logic [31:0] pc_in,
   input  logic        instr_valid,
   input  logic        stall,
   input  logic        flush,
   input  logic        thumb_mode,
   output logic [3:0]  condition,
   output logic [3:0]  instr_type,
   output logic [3:0]  alu_op,
   output logic [3:0]  rd,
   output logic [3:0]  rn,
   output logic [3:0]  rm,
   output logic [11:0] immediate,
   output logic        imm_en,
   output logic        set_flags,
   output logic        is_memory,
   output logic        mem_load,
   output logic        mem_byte,
   output logic        mem_pre,
   output logic        mem_up,
   output logic        mem_writeback,
   output logic [31:0] pc_out,
   output logic        decode_valid,
   output logic        is_branch,
   output logic [23:0] branch_offset,
   output logic        branch_link,
   output logic [1:0]  shift_type,
   output logic [4:0]  shift_amount,
   output logic        shift_reg,
   output logic [3:0]  shift_rs,
   output logic        psr_to_reg,
   output logic        psr_spsr,
   output logic        psr_immediate,
   output logic [3:0]  cp_op,
   output logic [3:0]  cp_num,
   output logic [3:0]  cp_rd,
   output logic [3:0]  cp_rn,
   output logic [2:0]  cp_opcode1,
   output logic [2:0]  cp_opcode2,
   output logic        cp_load,
   output logic [4:0]  thumb_instr_type,
   output logic [2:0]  thumb_rd,
   output logic [2:0]  thumb_rs,
   output logic [2:0]  thumb_rn,
   output logic [7:0]  thumb_imm8,
   output logic [4:0]  thumb_imm5,
   output logic [10:0] thumb_offset11,
   output logic [7:0]  thumb_offset8
);

   // Ordered so that the encodings overlapping DATA_PROC space are claimed first.
   function automatic instr_type_t arm_class(input logic [31:0] i);
      instr_type_t c;
      if (i[27:4] == 24'h12FFF1)                                          c = IT_BRANCH_EX;
      else if (i[27:22] == 6'b0 && i[7:4] == 4'b1001)                     c = IT_MUL;
      else if (i[27:23] == 5'b00001 && i[7:4] == 4'b1001)                 c = IT_MUL_LONG;
      else if (i[27:23] == 5'b00010 && i[21:20] == 2'b00 && i[11:4] == 8'h09) c = IT_SWAP;
      else if (i[27:25] == 3'b000 && i[7] && i[4])                        c = IT_HALF_DT;
      else if (i[27:26] == 2'b00 && i[24:23] == 2'b10 && !i[20])          c = IT_PSR;
      else if (i[27:26] == 2'b00)                                         c = IT_DATA_PROC;
      else if (i[27:25] == 3'b011 && i[4])                                c = IT_UNDEF;
      else if (i[27:26] == 2'b01)                                         c = IT_SINGLE_DT;
      else if (i[27:25] == 3'b100)                                        c = IT_BLOCK_DT;
      else if (i[27:25] == 3'b101)                                        c = IT_BRANCH;
      else if (i[27:25] == 3'b110)                                        c = IT_CP_DT;
      else if (i[27:24] == 4'b1110)                                       c = i[4] ? IT_CP_RT : IT_CP_OP;
      else                                                                c = IT_SWI;
      return c;
   endfunction

   function automatic logic [4:0] thumb_format(input logic [15:0] t);
      logic [4:0] f;
      f = 5'd0;
      if (t[15:11] == 5'b00011)                              f = 5'd2;
      else if (t[15:13] == 3'b000)                           f = 5'd1;
      else if (t[15:13] == 3'b001)                           f = 5'd3;
      else if (t[15:10] == 6'b010000)                        f = 5'd4;
      else if (t[15:10] == 6'b010001)                        f = 5'd5;
      else if (t[15:11] == 5'b01001)                         f = 5'd6;
      else if (t[15:12] == 4'b0101)                          f = t[9] ? 5'd8 : 5'd7;
      else if (t[15:13] == 3'b011)                           f = 5'd9;
      else if (t[15:12] == 4'b1000)                          f = 5'd10;
      else if (t[15:12] == 4'b1001)                          f = 5'd11;
      else if (t[15:12] == 4'b1010)                          f = 5'd12;
      else if (t[15:8] == 8'b1011_0000)                      f = 5'd13;
      else if (t[15:12] == 4'b1011 && t[10:9] == 2'b10)      f = 5'd14;
      else if (t[15:12] == 4'b1100)                          f = 5'd15;
      else if (t[15:8] == 8'b1101_1111)                      f = 5'd17;
      else if (t[15:12] == 4'b1101 && t[11:8] != 4'b1110)    f = 5'd16;
      else if (t[15:11] == 5'b11100)                         f = 5'd18;
      else if (t[15:12] == 4'b1111)                          f = 5'd19;
      return f;
   endfunction

   decode_t     dec_d, dec_q;
   instr_type_t cls;

   always_comb begin
      // NOTE: default the whole struct first so no branch below can infer a latch.
      dec_d = '0;
      cls   = arm_class(instruction);

      dec_d.pc            = pc_in;
      dec_d.valid         = instr_valid;
      dec_d.rd            = instruction[15:12];
      dec_d.rn            = instruction[19:16];
      dec_d.rm            = instruction[3:0];
      dec_d.immediate     = instruction[11:0];
      dec_d.branch_offset = instruction[23:0];
      dec_d.shift_type    = instruction[6:5];
      dec_d.shift_amount  = instruction[11:7];
      dec_d.shift_rs      = instruction[11:8];
      dec_d.cp_op         = instruction[23:20];
      dec_d.cp_num        = instruction[11:8];
      dec_d.cp_rd         = instruction[15:12];
      dec_d.cp_rn         = instruction[19:16];
      dec_d.cp_opcode1    = instruction[23:21];
      dec_d.cp_opcode2    = instruction[7:5];
      dec_d.cp_load       = instruction[20];

      if (thumb_mode) begin
         dec_d.condition        = COND_AL;
         dec_d.thumb_instr_type = thumb_format(instruction[15:0]);
         dec_d.thumb_rd         = instruction[2:0];
         dec_d.thumb_rs         = instruction[5:3];
         dec_d.thumb_rn         = instruction[8:6];
         dec_d.thumb_imm8       = instruction[7:0];
         dec_d.thumb_imm5       = instruction[10:6];
         dec_d.thumb_offset11   = instruction[10:0];
         dec_d.thumb_offset8    = instruction[7:0];
      end else begin
         dec_d.condition  = condition_t'(instruction[31:28]);
         dec_d.instr_type = cls;
         case (cls)
            IT_DATA_PROC: begin
               dec_d.alu_op    = alu_op_t'(instruction[24:21]);
               dec_d.set_flags = instruction[20];
               dec_d.imm_en    = instruction[25];
               dec_d.shift_reg = !instruction[25] && instruction[4];
            end
            IT_MUL:       dec_d.set_flags = instruction[20];
            IT_SINGLE_DT: dec_d.imm_en    = !instruction[25];
            IT_BRANCH: begin
               dec_d.is_branch   = 1'b1;
               dec_d.branch_link = instruction[24];
            end
            IT_PSR: begin
               dec_d.psr_to_reg    = !instruction[21];
               dec_d.psr_spsr      = instruction[22];
               dec_d.psr_immediate = instruction[25];
            end
            default: ;
         endcase
         if (cls inside {IT_SINGLE_DT, IT_HALF_DT, IT_BLOCK_DT, IT_SWAP}) begin
            dec_d.is_memory     = 1'b1;
            dec_d.mem_load      = instruction[20];
            dec_d.mem_byte      = instruction[22];
            dec_d.mem_pre       = instruction[24];
            dec_d.mem_up        = instruction[23];
            dec_d.mem_writeback = instruction[21];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst)         dec_q       <= '0;
      else if (flush)  dec_q.valid <= 1'b0;
      else if (!stall) dec_q       <= dec_d;
   end

   assign condition        = dec_q.condition;
   assign instr_type       = dec_q.instr_type;
   assign alu_op           = dec_q.alu_op;
   assign rd               = dec_q.rd;
   assign rn               = dec_q.rn;
   assign rm               = dec_q.rm;
   assign immediate        = dec_q.immediate;
   assign imm_en           = dec_q.imm_en;
   assign set_flags        = dec_q.set_flags;
   assign is_memory        = dec_q.is_memory;
   assign mem_load         = dec_q.mem_load;
   assign mem_byte         = dec_q.mem_byte;
   assign mem_pre          = dec_q.mem_pre;
   assign mem_up           = dec_q.mem_up;
   assign mem_writeback    = dec_q.mem_writeback;
   assign pc_out           = dec_q.pc;
   assign decode_valid     = dec_q.valid;
   assign is_branch        = dec_q.is_branch;
   assign branch_offset    = dec_q.branch_offset;
   assign branch_link      = dec_q.branch_link;
   assign shift_type       = dec_q.shift_type;
   assign shift_amount     = dec_q.shift_amount;
   assign shift_reg        = dec_q.shift_reg;
   assign shift_rs         = dec_q.shift_rs;
   assign psr_to_reg       = dec_q.psr_to_reg;
   assign psr_spsr         = dec_q.psr_spsr;
   assign psr_immediate    = dec_q.psr_immediate;
   assign cp_op            = dec_q.cp_op;
   assign cp_num           = dec_q.cp_num;
   assign cp_rd            = dec_q.cp_rd;
   assign cp_rn            = dec_q.cp_rn;
   assign cp_opcode1       = dec_q.cp_opcode1;
   assign cp_opcode2       = dec_q.cp_opcode2;
   assign cp_load          = dec_q.cp_load;
   assign thumb_instr_type = dec_q.thumb_instr_type;
   assign thumb_rd         = dec_q.thumb_rd;
   assign thumb_rs         = dec_q.thumb_rs;
   assign thumb_rn         = dec_q.thumb_rn;
   assign thumb_imm8       = dec_q.thumb_imm8;
   assign thumb_imm5       = dec_q.thumb_imm5;
   assign thumb_offset11   = dec_q.thumb_offset11;
   assign thumb_offset8    = dec_q.thumb_offset8;

endmodule

// File: tb/tb_arm7tdmi_instr_decode.sv
// Directed bench for arm7tdmi_instr_decode: a vector table of ARM and Thumb
// encodings with hand-computed fields, plus reset/stall/flush sequences.

module tb_arm7tdmi_instr_decode;

   logic        clk = 1'b0;
   logic        rst, instr_valid, stall, flush, thumb_mode;
   logic [31:0] instruction, pc_in;

   logic [3:0]  condition, instr_type, alu_op, rd, rn, rm;
   logic [11:0] immediate;
   logic        imm_en, set_flags, is_memory, mem_load, mem_byte, mem_pre, mem_up, mem_writeback;
   logic [31:0] pc_out;
   logic        decode_valid, is_branch, branch_link, shift_reg;
   logic [23:0] branch_offset;
   logic [1:0]  shift_type;
   logic [4:0]  shift_amount;
   logic [3:0]  shift_rs;
   logic        psr_to_reg, psr_spsr, psr_immediate;
   logic [3:0]  cp_op, cp_num, cp_rd, cp_rn;
   logic [2:0]  cp_opcode1, cp_opcode2;
   logic        cp_load;
   logic [4:0]  thumb_instr_type;
   logic [2:0]  thumb_rd, thumb_rs, thumb_rn;
   logic [7:0]  thumb_imm8, thumb_offset8;
   logic [4:0]  thumb_imm5;
   logic [10:0] thumb_offset11;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   arm7tdmi_instr_decode dut (
      .clk(clk), .rst(rst), .instruction(instruction), .pc_in(pc_in),
      .instr_valid(instr_valid), .stall(stall), .flush(flush), .thumb_mode(thumb_mode),
      .condition(condition), .instr_type(instr_type), .alu_op(alu_op),
      .rd(rd), .rn(rn), .rm(rm), .immediate(immediate), .imm_en(imm_en),
      .set_flags(set_flags), .is_memory(is_memory), .mem_load(mem_load),
      .mem_byte(mem_byte), .mem_pre(mem_pre), .mem_up(mem_up),
      .mem_writeback(mem_writeback), .pc_out(pc_out), .decode_valid(decode_valid),
      .is_branch(is_branch), .branch_offset(branch_offset), .branch_link(branch_link),
      .shift_type(shift_type), .shift_amount(shift_amount), .shift_reg(shift_reg),
      .shift_rs(shift_rs), .psr_to_reg(psr_to_reg), .psr_spsr(psr_spsr),
      .psr_immediate(psr_immediate), .cp_op(cp_op), .cp_num(cp_num),
      .cp_rd(cp_rd), .cp_rn(cp_rn), .cp_opcode1(cp_opcode1), .cp_opcode2(cp_opcode2),
      .cp_load(cp_load), .thumb_instr_type(thumb_instr_type), .thumb_rd(thumb_rd),
      .thumb_rs(thumb_rs), .thumb_rn(thumb_rn), .thumb_imm8(thumb_imm8),
      .thumb_imm5(thumb_imm5), .thumb_offset11(thumb_offset11), .thumb_offset8(thumb_offset8)
   );

   typedef struct {
      logic        thumb;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [3:0]  typ, cond, alu;
      logic        chk_regs;
      logic [3:0]  rd, rn, rm;
      logic        isb, bl;
      logic [23:0] off;
      logic        mem, ld, pre, up, sf, ie, mrs;
      logic [4:0]  ttype;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic th, input logic [31:0] ins, input logic [31:0] p,
                        input logic v, input logic s, input logic f);
      @(negedge clk);
      thumb_mode  = th;
      instruction = ins;
      pc_in       = p;
      instr_valid = v;
      stall       = s;
      flush       = f;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add_arm(input logic [31:0] ins, input logic [31:0] p, input logic [3:0] typ,
                          input logic [3:0] alu, input logic [3:0] d, input logic [3:0] n,
                          input logic [3:0] m, input logic isb, input logic bl,
                          input logic mem, input logic ld, input logic pre, input logic up,
                          input logic sf, input logic ie, input logic mrs);
      vec_t v;
      v.thumb = 1'b0; v.instr = ins; v.pc = p; v.typ = typ; v.cond = ins[31:28];
      v.alu = alu; v.chk_regs = 1'b1; v.rd = d; v.rn = n; v.rm = m;
      v.isb = isb; v.bl = bl; v.off = ins[23:0]; v.mem = mem; v.ld = ld;
      v.pre = pre; v.up = up; v.sf = sf; v.ie = ie; v.mrs = mrs; v.ttype = 5'd0;
      vecs.push_back(v);
   endtask

   task automatic add_thumb(input logic [15:0] half, input logic [4:0] ttype);
      vec_t v;
      v = '{default: '0};
      v.thumb = 1'b1; v.instr = {16'hF090, half}; v.pc = 32'h0000_8000;
      v.cond = 4'hE; v.off = {8'h90, half}; v.ttype = ttype;
      vecs.push_back(v);
   endtask

   initial begin
      rst = 1'b1; thumb_mode = 1'b0; instruction = 32'hEA000001; pc_in = 32'h1000;
      instr_valid = 1'b1; stall = 1'b0; flush = 1'b0;

      //        instr         pc         type  alu   rd    rn    rm    isb bl  mem ld  pre up  sf  ie  mrs
      add_arm(32'hEA000001, 32'h1000, 4'd9,  4'd0, 4'h0, 4'h0, 4'h1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      add_arm(32'hEB000018, 32'h2000, 4'd9,  4'd0, 4'h0, 4'h0, 4'h8, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      add_arm(32'hEA800000, 32'h2004, 4'd9,  4'd0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      add_arm(32'hEA7FFFFF, 32'h2008, 4'd9,  4'd0, 4'hF, 4'hF, 4'hF, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      add_arm(32'h0A000003, 32'h3000, 4'd9,  4'd0, 4'h0, 4'h0, 4'h3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      add_arm(32'h4A000001, 32'h3004, 4'd9,  4'd0, 4'h0, 4'h0, 4'h1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      add_arm(32'h2A000002, 32'h3008, 4'd9,  4'd0, 4'h0, 4'h0, 4'h2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      add_arm(32'hCA000004, 32'h300C, 4'd9,  4'd0, 4'h0, 4'h0, 4'h4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      add_arm(32'hDA000003, 32'h3010, 4'd9,  4'd0, 4'h0, 4'h0, 4'h3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      add_arm(32'hFA000005, 32'h3014, 4'd9,  4'd0, 4'h0, 4'h0, 4'h5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      add_arm(32'hE12FFF10, 32'h4000, 4'd4,  4'd0, 4'hF, 4'hF, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add_arm(32'hE12FFF11, 32'h4004, 4'd4,  4'd0, 4'hF, 4'hF, 4'h1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add_arm(32'hE0912003, 32'h5000, 4'd0,  4'd4, 4'h2, 4'h1, 4'h3, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add_arm(32'hE3A01005, 32'h5004, 4'd0,  4'hD, 4'h1, 4'h0, 4'h5, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      add_arm(32'hE5912004, 32'h5008, 4'd6,  4'd0, 4'h2, 4'h1, 4'h4, 0, 0, 1, 1, 1, 1, 0, 1, 0);
      add_arm(32'hE0100291, 32'h500C, 4'd1,  4'd0, 4'h0, 4'h0, 4'h1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add_arm(32'hE0810392, 32'h5010, 4'd2,  4'd0, 4'h0, 4'h1, 4'h2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add_arm(32'hE1012092, 32'h5014, 4'd3,  4'd0, 4'h2, 4'h1, 4'h2, 0, 0, 1, 0, 1, 0, 0, 0, 0);
      add_arm(32'hE1D120B0, 32'h5018, 4'd5,  4'd0, 4'h2, 4'h1, 4'h0, 0, 0, 1, 1, 1, 1, 0, 0, 0);
      add_arm(32'hE10F0000, 32'h501C, 4'd14, 4'd0, 4'h0, 4'hF, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      add_arm(32'hE6000010, 32'h5020, 4'd7,  4'd0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add_arm(32'hE8BD000F, 32'h5024, 4'd8,  4'd0, 4'h0, 4'hD, 4'hF, 0, 0, 1, 1, 0, 1, 0, 0, 0);
      add_arm(32'hEC900100, 32'h5028, 4'd10, 4'd0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add_arm(32'hEE000000, 32'h502C, 4'd11, 4'd0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add_arm(32'hEE100F10, 32'h5030, 4'd12, 4'd0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add_arm(32'hEF000010, 32'h5034, 4'd13, 4'd0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      add_thumb(16'h0088, 5'd1);  add_thumb(16'h1888, 5'd2);  add_thumb(16'h2005, 5'd3);
      add_thumb(16'h4008, 5'd4);  add_thumb(16'h4770, 5'd5);  add_thumb(16'h4801, 5'd6);
      add_thumb(16'h5088, 5'd7);  add_thumb(16'h5288, 5'd8);  add_thumb(16'h6808, 5'd9);
      add_thumb(16'h8808, 5'd10); add_thumb(16'h9801, 5'd11); add_thumb(16'hA001, 5'd12);
      add_thumb(16'hB001, 5'd13); add_thumb(16'hB401, 5'd14); add_thumb(16'hC801, 5'd15);
      add_thumb(16'hD001, 5'd16); add_thumb(16'hDF01, 5'd17); add_thumb(16'hE001, 5'd18);
      add_thumb(16'hF000, 5'd19); add_thumb(16'hDE00, 5'd0);  add_thumb(16'hE801, 5'd0);

      // Reset with a valid instruction present must still clear everything.
      tick(); tick();
      check("rst decode_valid", 32'(decode_valid), 32'd0);
      check("rst pc_out", pc_out, 32'd0);
      check("rst instr_type", 32'(instr_type), 32'd0);
      check("rst condition", 32'(condition), 32'd0);
      check("rst branch_offset", 32'(branch_offset), 32'd0);
      check("rst is_branch", 32'(is_branch), 32'd0);
      check("rst immediate", 32'(immediate), 32'd0);
      check("rst thumb_instr_type", 32'(thumb_instr_type), 32'd0);
      @(negedge clk); rst = 1'b0;

      foreach (vecs[k]) begin
         vec_t v;
         v = vecs[k];
         drive(v.thumb, v.instr, v.pc, 1'b1, 1'b0, 1'b0);
         tick();
         check($sformatf("v%0d decode_valid", k), 32'(decode_valid), 32'd1);
         check($sformatf("v%0d pc_out", k), pc_out, v.pc);
         check($sformatf("v%0d instr_type", k), 32'(instr_type), 32'(v.typ));
         check($sformatf("v%0d condition", k), 32'(condition), 32'(v.cond));
         check($sformatf("v%0d alu_op", k), 32'(alu_op), 32'(v.alu));
         check($sformatf("v%0d is_branch", k), 32'(is_branch), 32'(v.isb));
         check($sformatf("v%0d branch_link", k), 32'(branch_link), 32'(v.bl));
         check($sformatf("v%0d branch_offset", k), 32'(branch_offset), 32'(v.off));
         check($sformatf("v%0d is_memory", k), 32'(is_memory), 32'(v.mem));
         check($sformatf("v%0d mem_load", k), 32'(mem_load), 32'(v.ld));
         check($sformatf("v%0d mem_pre", k), 32'(mem_pre), 32'(v.pre));
         check($sformatf("v%0d mem_up", k), 32'(mem_up), 32'(v.up));
         check($sformatf("v%0d set_flags", k), 32'(set_flags), 32'(v.sf));
         check($sformatf("v%0d imm_en", k), 32'(imm_en), 32'(v.ie));
         check($sformatf("v%0d psr_to_reg", k), 32'(psr_to_reg), 32'(v.mrs));
         check($sformatf("v%0d thumb_instr_type", k), 32'(thumb_instr_type), 32'(v.ttype));
         if (v.chk_regs) begin
            check($sformatf("v%0d rd", k), 32'(rd), 32'(v.rd));
            check($sformatf("v%0d rn", k), 32'(rn), 32'(v.rn));
            check($sformatf("v%0d rm", k), 32'(rm), 32'(v.rm));
         end
      end

      // Thumb operand fields, then the same halfword in ARM mode zeroes them.
      drive(1'b1, 32'hF0901888, 32'h9000, 1'b1, 1'b0, 1'b0);
      tick();
      check("thumb rd", 32'(thumb_rd), 32'd0);
      check("thumb rs", 32'(thumb_rs), 32'd1);
      check("thumb rn", 32'(thumb_rn), 32'd2);
      check("thumb imm5", 32'(thumb_imm5), 32'd2);
      check("thumb imm8", 32'(thumb_imm8), 32'h88);
      check("thumb offset11", 32'(thumb_offset11), 32'h088);
      check("thumb offset8", 32'(thumb_offset8), 32'h88);
      drive(1'b0, 32'hE0001888, 32'h9004, 1'b1, 1'b0, 1'b0);
      tick();
      check("arm thumb_rs zero", 32'(thumb_rs), 32'd0);
      check("arm thumb_imm8 zero", 32'(thumb_imm8), 32'd0);
      check("arm thumb_offset11 zero", 32'(thumb_offset11), 32'd0);

      // Stall freezes outputs against a new instruction.
      drive(1'b0, 32'hEA000001, 32'h1000, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, 32'hE0912003, 32'h3000, 1'b1, 1'b1, 1'b0);
      tick();
      check("stall pc_out", pc_out, 32'h1000);
      check("stall instr_type", 32'(instr_type), 32'd9);
      check("stall branch_offset", 32'(branch_offset), 32'd1);
      check("stall decode_valid", 32'(decode_valid), 32'd1);
      check("stall rd", 32'(rd), 32'd0);
      drive(1'b0, 32'hE0912003, 32'h3000, 1'b1, 1'b0, 1'b0);
      tick();
      check("unstall pc_out", pc_out, 32'h3000);
      check("unstall alu_op", 32'(alu_op), 32'd4);

      // Flush, and flush winning over stall.
      drive(1'b0, 32'hEA000001, 32'h1000, 1'b1, 1'b0, 1'b1);
      tick();
      check("flush decode_valid", 32'(decode_valid), 32'd0);
      drive(1'b0, 32'hEA000001, 32'h1000, 1'b1, 1'b0, 1'b0);
      tick();
      check("reload decode_valid", 32'(decode_valid), 32'd1);
      drive(1'b0, 32'hEA000001, 32'h1000, 1'b1, 1'b1, 1'b1);
      tick();
      check("flush+stall decode_valid", 32'(decode_valid), 32'd0);

      // instr_valid low still loads fields but marks them dead.
      drive(1'b0, 32'hEA000001, 32'h4000, 1'b0, 1'b0, 1'b0);
      tick();
      check("invalid decode_valid", 32'(decode_valid), 32'd0);
      check("invalid pc_out", pc_out, 32'h4000);

      // Holding the same input re-decodes identically.
      for (int c = 0; c < 2; c++) begin
         drive(1'b0, 32'hE5912004, 32'h6000, 1'b1, 1'b0, 1'b0);
         tick();
         check($sformatf("repeat%0d mem_load", c), 32'(mem_load), 32'd1);
         check($sformatf("repeat%0d rd", c), 32'(rd), 32'd2);
         check($sformatf("repeat%0d pc_out", c), pc_out, 32'h6000);
      end

      // Reset after live data.
      @(negedge clk); rst = 1'b1;
      tick();
      check("rst2 decode_valid", 32'(decode_valid), 32'd0);
      check("rst2 pc_out", pc_out, 32'd0);
      check("rst2 rd", 32'(rd), 32'd0);
      check("rst2 is_memory", 32'(is_memory), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/arm7tdmi_instr_decode.md
# arm7tdmi_instr_decode

Registered instruction-decode stage of the ARM7TDMI core. It sits between fetch and execute. It splits a fetched 32-bit ARM word, or a 16-bit Thumb halfword, into condition, class, ALU, register, immediate, memory, branch, shift, PSR and coprocessor fields. It forwards the instruction's PC alongside the decoded fields. It does not evaluate conditions, compute targets or access the register file.

## Interface
- No parameters. Enumerated types come from arm7tdmi_pkg.
- Reset is synchronous and active-high, on a single clock `clk`.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- instruction  in  32  fetched word; Thumb uses [15:0]
- pc_in  in  32  address of `instruction`
- instr_valid  in  1  `instruction` is valid this cycle
- stall  in  1  hold all outputs
- flush  in  1  kill the decoded instruction
- thumb_mode  in  1  decode as Thumb
- condition  out  4  (condition_t) bits [31:28]; 4'hE in Thumb
- instr_type  out  4  (instr_type_t): 0 DATA_PROC, 1 MUL, 2 MUL_LONG, 3 SWAP, 4 BRANCH_EX, 5 HALF_DT, 6 SINGLE_DT, 7 UNDEF, 8 BLOCK_DT, 9 BRANCH, 10 CP_DT, 11 CP_OP, 12 CP_RT, 13 SWI, 14 PSR
- alu_op  out  4  (alu_op_t) bits [24:21] for DATA_PROC, else 0
- rd/rn/rm  out  4 each  bits [15:12] / [19:16] / [3:0]
- immediate  out  12  bits [11:0]
- imm_en  out  1  I bit [25] for DATA_PROC; for SINGLE_DT, ~[25]
- set_flags  out  1  S bit [20] for DATA_PROC/MUL
- is_memory  out  1  class is SINGLE_DT, HALF_DT, BLOCK_DT or SWAP
- mem_load, mem_byte, mem_pre, mem_up, mem_writeback  out  1 each  L[20], B[22], P[24], U[23], W[21]
- pc_out  out  32  registered pc_in
- decode_valid  out  1  outputs hold a live instruction
- is_branch  out  1  B/BL only
- branch_offset  out  24  bits [23:0], raw, not shifted or extended
- branch_link  out  1  L bit [24] of B/BL
- shift_type  out  2  bits [6:5]
- shift_amount  out  5  bits [11:7]
- shift_reg  out  1  bit [4] of register-operand DATA_PROC
- shift_rs  out  4  bits [11:8]
- psr_to_reg, psr_spsr, psr_immediate  out  1 each  MRS, bit [22], bit [25]
- cp_op  out  4  bits [23:20]
- cp_num  out  4  bits [11:8]
- cp_rd, cp_rn  out  4 each  bits [15:12], [19:16]
- cp_opcode1  out  3  bits [23:21]
- cp_opcode2  out  3  bits [7:5]
- cp_load  out  1  bit [20]
- thumb_instr_type  out  5  Thumb format 1–19; 0 = undefined
- thumb_rd/rs/rn  out  3 each  [2:0] / [5:3] / [8:6]
- thumb_imm8, thumb_imm5, thumb_offset11, thumb_offset8  out  8/5/11/8  [7:0], [10:6], [10:0], [7:0]

## Operation
- **Class priority**, first match wins:
  - BX: [27:4] = 0x12FFF1
  - MUL: [27:22] = 0, [7:4] = 1001
  - MUL_LONG: [27:23] = 00001, [7:4] = 1001
  - SWAP: [27:23] = 00010, [21:20] = 00, [11:4] = 00001001
  - HALF_DT: [27:25] = 000, [7] = 1, [4] = 1
  - PSR: [27:26] = 00, [24:23] = 10, [20] = 0
  - DATA_PROC: [27:26] = 00
  - UNDEF: [27:25] = 011, [4] = 1
  - SINGLE_DT: [27:26] = 01
  - BLOCK_DT: [27:25] = 100
  - BRANCH: [27:25] = 101
  - CP_DT: [27:25] = 110
  - CP_OP: [27:24] = 1110, [4] = 0
  - CP_RT: [27:24] = 1110, [4] = 1
  - SWI: [27:24] = 1111
- **Field gating**: fields are extracted unconditionally. Class-qualified flags (is_branch, branch_link, is_memory, mem_*, set_flags, imm_en, psr_*, shift_reg, alu_op) are 0 outside their class.
- **Condition 4'hF** is passed through unchanged; the decoder does not reject it.
- **Thumb mode**:
  - Format is chosen by the standard ARM7TDMI Thumb opcode prefix map, checked most specific first.
  - ARM class flags are 0; instr_type is 0; condition is 4'hE.
  - When thumb_mode = 0, all thumb_* outputs are 0.

## Timing
- All outputs are registered; latency is 1 cycle from the sampling edge.
- Reset: every output is 0, including decode_valid.
- On each edge, priority is rst > flush > stall > load:
  - flush: decode_valid ← 0; other outputs are don't-care.
  - stall: all outputs hold.
  - else: decode_valid ← instr_valid, and every field is loaded from the current inputs.
- flush together with stall: flush wins.
- An unchanged input re-decodes to identical outputs each cycle.

## Test plan
- EA000001, pc_in 0x1000, valid → next cycle: condition E, is_branch 1, branch_link 0, branch_offset 0x000001, instr_type BRANCH, pc_out 0x1000, decode_valid 1.
- EB000018, pc_in 0x2000 → branch_link 1, branch_offset 0x000018. EA800000 → 0x800000. EA7FFFFF → 0x7FFFFF.
- Condition field: 0A000003 → condition 0; 4A000001 → 4; 2A000002 → 2; CA000004 → C; DA000003 → D. Each has branch_offset equal to its low 24 bits.
- BX: E12FFF10 → instr_type BRANCH_EX, rm 0, is_branch 0. E12FFF11 → rm 1.
- E0912003 (ADDS R2,R1,R3) → DATA_PROC, alu_op 4, set_flags 1, rd 2, rn 1, rm 3. E5912004 → SINGLE_DT, is_memory 1, mem_load 1, mem_pre 1, mem_up 1.
- Control:
  - rst high → all outputs 0.
  - stall → outputs frozen despite a new instruction.
  - flush → decode_valid 0 next cycle.
  - instr_valid 0 → decode_valid 0.
